// File: rtl/sram_req_resp_adapter.sv
// Single-port SRAM behind val/rdy request/response ports, with a 2-entry response queue.
// Optional macro SRAM_INIT_EN: zero-fill the whole array after every reset before accepting requests.
module sram_req_resp_adapter #(
  parameter int DATA_NBITS  = 32,
  parameter int NUM_ENTRIES = 1024,
  parameter int ADDR_NBITS  = $clog2(NUM_ENTRIES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_val,
  output logic                    req_rdy,
  input  logic                    req_type,
  input  logic [ADDR_NBITS-1:0]   req_addr,
  input  logic [DATA_NBITS-1:0]   req_data,
  input  logic [DATA_NBITS/8-1:0] req_wmask,
  output logic                    resp_val,
  input  logic                    resp_rdy,
  output logic                    resp_type,
  output logic [DATA_NBITS-1:0]   resp_data,
  output logic                    resp_err,
  output logic                    busy
);
  localparam int          NBYTES        = DATA_NBITS / 8;
  localparam int unsigned NUM_ENTRIES_U = NUM_ENTRIES;

  logic [DATA_NBITS-1:0] mem [NUM_ENTRIES];
  logic [DATA_NBITS-1:0] rd_data_q;

  logic s1_val_q, s1_val_d;
  logic s1_type_q, s1_type_d;
  logic s1_err_q, s1_err_d;

  logic                  q_type_q [2];
  logic                  q_type_d [2];
  logic                  q_err_q  [2];
  logic                  q_err_d  [2];
  logic [DATA_NBITS-1:0] q_data_q [2];
  logic [DATA_NBITS-1:0] q_data_d [2];
  logic                  q_rd_ptr_q, q_rd_ptr_d;
  logic                  q_wr_ptr_q, q_wr_ptr_d;
  logic [1:0]            q_count_q, q_count_d;

  logic       req_fire;
  logic       addr_ok;
  logic       deq;
  logic       push;
  logic       init_active;
  logic [2:0] occupancy;

`ifdef SRAM_INIT_EN
  // state   | meaning
  // ST_INIT | zero-filling the array, one word per cycle; requests blocked
  // ST_RUN  | normal request/response operation
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_NBITS-1:0] init_addr_q, init_addr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      if (32'(init_addr_q) == NUM_ENTRIES_U - 1) state_d = ST_RUN;
      else init_addr_d = init_addr_q + ADDR_NBITS'(1);
    end
  end

  assign init_active = (state_q == ST_INIT);
`else
  assign init_active = 1'b0;
`endif

  assign resp_val  = (q_count_q != 2'd0);
  assign deq       = resp_val && resp_rdy;
  assign push      = s1_val_q;
  // Room is judged after this cycle's push/pop so a full queue that is draining still accepts.
  assign occupancy = {1'b0, q_count_q} + {2'b00, s1_val_q} - {2'b00, deq};
  assign req_rdy   = !init_active && (occupancy < 3'd2);
  assign req_fire  = req_val && req_rdy;
  assign addr_ok   = (32'(req_addr) < NUM_ENTRIES_U);

  always_ff @(posedge clk) begin
`ifdef SRAM_INIT_EN
    if (init_active) mem[init_addr_q] <= '0;
`endif
    if (req_fire && addr_ok) begin
      if (req_type) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (req_wmask[i]) mem[req_addr][i*8 +: 8] <= req_data[i*8 +: 8];
        end
      end else begin
        rd_data_q <= mem[req_addr];
      end
    end
  end

  always_comb begin
    s1_val_d  = req_fire;
    s1_type_d = s1_type_q;
    s1_err_d  = s1_err_q;
    if (req_fire) begin
      s1_type_d = req_type;
      s1_err_d  = !addr_ok;
    end
  end

  always_comb begin
    q_type_d   = q_type_q;
    q_err_d    = q_err_q;
    q_data_d   = q_data_q;
    q_wr_ptr_d = q_wr_ptr_q;
    q_rd_ptr_d = q_rd_ptr_q;
    q_count_d  = q_count_q + {1'b0, push} - {1'b0, deq};
    if (push) begin
      q_type_d[q_wr_ptr_q] = s1_type_q;
      q_err_d[q_wr_ptr_q]  = s1_err_q;
      q_data_d[q_wr_ptr_q] = (s1_type_q || s1_err_q) ? '0 : rd_data_q;
      q_wr_ptr_d           = !q_wr_ptr_q;
    end
    if (deq) q_rd_ptr_d = !q_rd_ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_val_q   <= 1'b0;
      s1_type_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      q_wr_ptr_q <= 1'b0;
      q_rd_ptr_q <= 1'b0;
      q_count_q  <= 2'd0;
    end else begin
      s1_val_q   <= s1_val_d;
      s1_type_q  <= s1_type_d;
      s1_err_q   <= s1_err_d;
      q_wr_ptr_q <= q_wr_ptr_d;
      q_rd_ptr_q <= q_rd_ptr_d;
      q_count_q  <= q_count_d;
    end
  end

  // Queue payload needs no reset: every output is gated by resp_val.
  always_ff @(posedge clk) begin
    q_type_q <= q_type_d;
    q_err_q  <= q_err_d;
    q_data_q <= q_data_d;
  end

  assign resp_type = resp_val && q_type_q[q_rd_ptr_q];
  assign resp_err  = resp_val && q_err_q[q_rd_ptr_q];
  assign resp_data = resp_val ? q_data_q[q_rd_ptr_q] : '0;
  assign busy      = s1_val_q || resp_val || init_active;

endmodule

// File: tb/tb_sram_req_resp_adapter.sv
// Directed bench for sram_req_resp_adapter with NUM_ENTRIES=1000 (non power of 2).
// Responses are logged at the falling edge with a cycle stamp; each test task checks its own.
module tb_sram_req_resp_adapter;
  localparam int DW = 32;
  localparam int NE = 1000;
  localparam int AW = $clog2(NE);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_val = 1'b0;
  logic          req_rdy;
  logic          req_type = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [3:0]    req_wmask = '0;
  logic          resp_val;
  logic          resp_rdy = 1'b1;
  logic          resp_type;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic          t;
    logic          e;
    logic [DW-1:0] d;
    int            c;
  } resp_t;
  resp_t rq[$];

  sram_req_resp_adapter #(.DATA_NBITS(DW), .NUM_ENTRIES(NE)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_wmask (req_wmask),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_type (resp_type),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    resp_t r;
    if (!reset && resp_val && resp_rdy) begin
      r.t = resp_type; r.e = resp_err; r.d = resp_data; r.c = cyc;
      rq.push_back(r);
    end
  end

  task automatic do_req(input logic t, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] m, output int acc);
    req_val = 1'b1; req_type = t; req_addr = a; req_data = d; req_wmask = m;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (req_rdy) begin
        acc = cyc;
        @(posedge clk); #1;
        req_val = 1'b0;
        return;
      end
    end
    $display("FAIL req_accept_timeout: req_rdy stayed 0, needed 1");
    $fatal(1, "request never accepted");
  endtask

  task automatic wait_resp(input int n);
    for (int i = 0; i < 4000; i++) begin
      if (rq.size() >= n) return;
      @(posedge clk); #1;
    end
    $display("FAIL resp_timeout: got %0d responses, needed %0d", rq.size(), n);
    $fatal(1, "responses never arrived");
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(posedge clk);
    #4;
    n_vec++; if (resp_val !== 1'b0) begin n_err++; $display("FAIL rst_resp_val: got %b need 0", resp_val); end
    n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp_err: got %b need 0", resp_err); end
    n_vec++; if (resp_type !== 1'b0) begin n_err++; $display("FAIL rst_resp_type: got %b need 0", resp_type); end
    n_vec++; if (resp_data !== 32'h0) begin n_err++; $display("FAIL rst_resp_data: got %h need 0", resp_data); end
    reset = 1'b0;
`ifdef SRAM_INIT_EN
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_init_busy: got %b need 1", busy); end
    n = 0;
    while (!req_rdy && n < NE + 16) begin @(posedge clk); #1; n++; end
    n_vec++; if (n != NE) begin n_err++; $display("FAIL rst_init_cycles: got %0d need %0d", n, NE); end
`else
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b need 0", busy); end
    @(posedge clk); #1;
    n_vec++; if (req_rdy !== 1'b1) begin n_err++; $display("FAIL rst_req_rdy: got %b need 1", req_rdy); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int a0, a1;
    resp_t r;
    resp_rdy = 1'b1;
    do_req(1'b1, AW'(5), 32'hDEADBEEF, 4'hF, a0);
    do_req(1'b0, AW'(5), 32'h0, 4'h0, a1);
    wait_resp(2);
    r = rq.pop_front();
    n_vec++; if (r.t !== 1'b1 || r.d !== 32'h0 || r.e !== 1'b0) begin n_err++; $display("FAIL wr_resp: got t=%b d=%h e=%b need t=1 d=0 e=0", r.t, r.d, r.e); end
    n_vec++; if (r.c != a0 + 2) begin n_err++; $display("FAIL wr_latency: got %0d need 2", r.c - a0); end
    r = rq.pop_front();
    n_vec++; if (r.t !== 1'b0 || r.d !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_resp: got t=%b d=%h need t=0 d=deadbeef", r.t, r.d); end
    n_vec++; if (r.c != a1 + 2) begin n_err++; $display("FAIL rd_latency: got %0d need 2", r.c - a1); end
  endtask

  task automatic test_byte_mask();
    int a;
    resp_t r;
    do_req(1'b1, AW'(7), 32'h11223344, 4'hF, a);
    do_req(1'b1, AW'(7), 32'hAABBCCDD, 4'b0101, a);
    do_req(1'b0, AW'(7), 32'h0, 4'h0, a);
    do_req(1'b1, AW'(7), 32'hFFFFFFFF, 4'h0, a);
    do_req(1'b0, AW'(7), 32'h0, 4'h0, a);
    wait_resp(5);
    void'(rq.pop_front()); void'(rq.pop_front());
    r = rq.pop_front();
    n_vec++; if (r.d !== 32'h11BB33DD) begin n_err++; $display("FAIL byte_mask: got %h need 11bb33dd", r.d); end
    r = rq.pop_front();
    n_vec++; if (r.t !== 1'b1 || r.d !== 32'h0) begin n_err++; $display("FAIL mask0_resp: got t=%b d=%h need t=1 d=0", r.t, r.d); end
    r = rq.pop_front();
    n_vec++; if (r.d !== 32'h11BB33DD) begin n_err++; $display("FAIL mask0_noop: got %h need 11bb33dd", r.d); end
  endtask

  task automatic test_backpressure();
    int idx, a;
    logic fire;
    resp_t r;
    for (int i = 0; i < 4; i++) do_req(1'b1, AW'(10 + i), 32'hB0000010 + 32'(i), 4'hF, a);
    wait_resp(4); rq.delete();
    resp_rdy = 1'b0;
    idx = 0;
    req_val = 1'b1; req_type = 1'b0; req_addr = AW'(10);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); fire = req_rdy;
      @(posedge clk); #1;
      if (fire) begin idx++; if (idx < 4) req_addr = AW'(10 + idx); else req_val = 1'b0; end
    end
    n_vec++; if (idx != 2) begin n_err++; $display("FAIL bp_accepted: got %0d need 2", idx); end
    n_vec++; if (req_rdy !== 1'b0) begin n_err++; $display("FAIL bp_req_rdy: got %b need 0", req_rdy); end
    n_vec++; if (resp_val !== 1'b1) begin n_err++; $display("FAIL bp_resp_val: got %b need 1", resp_val); end
    resp_rdy = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      @(negedge clk); fire = req_rdy;
      @(posedge clk); #1;
      if (fire) begin idx++; if (idx < 4) req_addr = AW'(10 + idx); else req_val = 1'b0; end
    end
    req_val = 1'b0;
    n_vec++; if (idx != 4) begin n_err++; $display("FAIL bp_drain_accept: got %0d need 4", idx); end
    wait_resp(4);
    for (int i = 0; i < 4; i++) begin
      r = rq.pop_front();
      n_vec++; if (r.t !== 1'b0 || r.d !== 32'hB0000010 + 32'(i)) begin n_err++; $display("FAIL bp_order[%0d]: got %h need %h", i, r.d, 32'hB0000010 + 32'(i)); end
    end
  endtask

  task automatic test_throughput();
    int acc [64];
    int a;
    resp_t r;
    resp_rdy = 1'b1;
    for (int i = 0; i < 64; i++) do_req(1'b1, AW'(100 + i), 32'hA5000000 + 32'(i), 4'hF, a);
    wait_resp(64); rq.delete();
    for (int i = 0; i < 64; i++) do_req(1'b0, AW'(100 + i), 32'h0, 4'h0, acc[i]);
    for (int i = 1; i < 64; i++) begin
      n_vec++; if (acc[i] != acc[0] + i) begin n_err++; $display("FAIL tput_accept[%0d]: got cycle %0d need %0d", i, acc[i], acc[0] + i); end
    end
    wait_resp(64);
    for (int i = 0; i < 64; i++) begin
      r = rq.pop_front();
      n_vec++; if (r.d !== 32'hA5000000 + 32'(i)) begin n_err++; $display("FAIL tput_data[%0d]: got %h need %h", i, r.d, 32'hA5000000 + 32'(i)); end
      n_vec++; if (r.c != acc[0] + 2 + i) begin n_err++; $display("FAIL tput_resp_cycle[%0d]: got %0d need %0d", i, r.c, acc[0] + 2 + i); end
    end
  endtask

  task automatic test_out_of_range();
    int a;
    resp_t r;
    do_req(1'b1, AW'(999), 32'hCAFEF00D, 4'hF, a);
    do_req(1'b1, AW'(488), 32'h48848848, 4'hF, a);
    wait_resp(2); rq.delete();
    do_req(1'b1, AW'(1000), 32'hFFFFFFFF, 4'hF, a);
    do_req(1'b0, AW'(1000), 32'h0, 4'h0, a);
    do_req(1'b0, AW'(999), 32'h0, 4'h0, a);
    do_req(1'b0, AW'(488), 32'h0, 4'h0, a);
    wait_resp(4);
    r = rq.pop_front();
    n_vec++; if (r.t !== 1'b1 || r.e !== 1'b1 || r.d !== 32'h0) begin n_err++; $display("FAIL oor_write: got t=%b e=%b d=%h need t=1 e=1 d=0", r.t, r.e, r.d); end
    r = rq.pop_front();
    n_vec++; if (r.t !== 1'b0 || r.e !== 1'b1 || r.d !== 32'h0) begin n_err++; $display("FAIL oor_read: got t=%b e=%b d=%h need t=0 e=1 d=0", r.t, r.e, r.d); end
    r = rq.pop_front();
    n_vec++; if (r.e !== 1'b0 || r.d !== 32'hCAFEF00D) begin n_err++; $display("FAIL oor_top_word: got e=%b d=%h need e=0 d=cafef00d", r.e, r.d); end
    r = rq.pop_front();
    n_vec++; if (r.e !== 1'b0 || r.d !== 32'h48848848) begin n_err++; $display("FAIL oor_alias_word: got e=%b d=%h need e=0 d=48848848", r.e, r.d); end
  endtask

  task automatic test_reset_mid();
    int a, n;
    resp_t r;
    logic [DW-1:0] exp20, exp10;
    resp_rdy = 1'b0;
    do_req(1'b1, AW'(20), 32'h5A5A1234, 4'hF, a);
    do_req(1'b0, AW'(10), 32'h0, 4'h0, a);
    @(posedge clk); #1;
    n_vec++; if (resp_val !== 1'b1 || req_rdy !== 1'b0) begin n_err++; $display("FAIL full_before_rst: got val=%b rdy=%b need val=1 rdy=0", resp_val, req_rdy); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (resp_val !== 1'b0) begin n_err++; $display("FAIL midrst_resp_val: got %b need 0", resp_val); end
    n_vec++; if (resp_data !== 32'h0) begin n_err++; $display("FAIL midrst_resp_data: got %h need 0", resp_data); end
`ifdef SRAM_INIT_EN
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy: got %b need 1", busy); end
`else
    n_vec++; if (busy !== 1'b0 || req_rdy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_rdy: got busy=%b rdy=%b need 0/1", busy, req_rdy); end
`endif
    repeat (2) @(posedge clk);
    #4 reset = 1'b0;
    rq.delete();
`ifdef SRAM_INIT_EN
    n = 0;
    while (!req_rdy && n < NE + 16) begin @(posedge clk); #1; n++; end
    n_vec++; if (n != NE) begin n_err++; $display("FAIL midrst_init_cycles: got %0d need %0d", n, NE); end
    exp20 = 32'h0; exp10 = 32'h0;
`else
    @(posedge clk); #1;
    n_vec++; if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin n_err++; $display("FAIL post_rst: got rdy=%b val=%b need 1/0", req_rdy, resp_val); end
    exp20 = 32'h5A5A1234; exp10 = 32'hB0000010;
`endif
    resp_rdy = 1'b1;
    do_req(1'b0, AW'(20), 32'h0, 4'h0, a);
    do_req(1'b0, AW'(10), 32'h0, 4'h0, a);
    wait_resp(2);
    r = rq.pop_front();
    n_vec++; if (r.d !== exp20) begin n_err++; $display("FAIL post_rst_addr20: got %h need %h", r.d, exp20); end
    r = rq.pop_front();
    n_vec++; if (r.d !== exp10) begin n_err++; $display("FAIL post_rst_addr10: got %h need %h", r.d, exp10); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_backpressure();
    test_throughput();
    test_out_of_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
